// File: rtl/pe_edge_es_tx.sv
`default_nettype none
// ============================================================================
// Module      : pe_edge_es_tx
// Description : East/south transmit edge of a PE; queues local words in a
//               4-entry FIFO and drives them onto the selected link.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_edge_es_tx #(
    parameter int EAST_WIDTH     = 130,
    parameter int SOUTH_WIDTH    = 130,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ap_start,
    input  logic [127:0]           local_in_data,
    input  logic                   local_in_dest,
    input  logic                   local_in_valid,
    output logic                   local_in_ready,
    input  logic [EAST_WIDTH-1:0]  in_from_east,
    input  logic [SOUTH_WIDTH-1:0] in_from_south,
    output logic [EAST_WIDTH-1:0]  out_to_east,
    output logic [SOUTH_WIDTH-1:0] out_to_south,
    output logic [31:0]            tx_count,
    output logic                   idle
);

    localparam int                  c_DEPTH   = 1 << FIFO_ADDR_BITS;
    localparam logic [FIFO_ADDR_BITS:0] c_FULL = {1'b1, {FIFO_ADDR_BITS{1'b0}}};
    localparam logic                c_ST_IDLE = 1'b0;
    localparam logic                c_ST_RUN  = 1'b1;

    logic                      r_state;
    logic [128:0]              r_mem [c_DEPTH];
    logic [FIFO_ADDR_BITS-1:0] r_wr_ptr;
    logic [FIFO_ADDR_BITS-1:0] r_rd_ptr;
    logic [FIFO_ADDR_BITS:0]   r_count;
    logic                      r_or_full;
    logic [128:0]              r_or_word;
    logic [EAST_WIDTH-1:0]     r_out_east;
    logic [SOUTH_WIDTH-1:0]    r_out_south;
    logic [31:0]               r_tx_count;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_xfer;
    logic                      w_or_full_nxt;
    logic [128:0]              w_or_word_nxt;
    logic [EAST_WIDTH-1:0]     w_east_nxt;
    logic [SOUTH_WIDTH-1:0]    w_south_nxt;
    logic                      w_unused;

    // Only the reverse ready bit of each return bus is meaningful here.
    assign w_unused = ^{in_from_east[EAST_WIDTH-1:129], in_from_east[127:0],
                        in_from_south[SOUTH_WIDTH-1:129], in_from_south[127:0]};

    assign local_in_ready = (r_state == c_ST_RUN) && (r_count != c_FULL);
    assign idle           = (r_state == c_ST_RUN) && (r_count == '0) && !r_or_full;
    assign out_to_east    = r_out_east;
    assign out_to_south   = r_out_south;
    assign tx_count       = r_tx_count;

    always_comb begin
        w_push        = local_in_valid && local_in_ready;
        w_xfer        = r_or_full && (r_or_word[128] ? in_from_south[128] : in_from_east[128]);
        w_pop         = (r_count != '0) && (!r_or_full || w_xfer);
        w_or_full_nxt = r_or_full;
        w_or_word_nxt = r_or_word;
        if (w_pop) begin
            w_or_full_nxt = 1'b1;
            w_or_word_nxt = r_mem[r_rd_ptr];
        end else if (w_xfer) begin
            w_or_full_nxt = 1'b0;
        end
        // Link buses are re-registered from the next OR contents so every bit is a flop.
        w_east_nxt  = '0;
        w_south_nxt = '0;
        if (w_or_full_nxt && !w_or_word_nxt[128]) begin
            w_east_nxt[129]   = 1'b1;
            w_east_nxt[127:0] = w_or_word_nxt[127:0];
        end
        if (w_or_full_nxt && w_or_word_nxt[128]) begin
            w_south_nxt[129]   = 1'b1;
            w_south_nxt[127:0] = w_or_word_nxt[127:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_or_full   <= 1'b0;
            r_or_word   <= '0;
            r_out_east  <= '0;
            r_out_south <= '0;
            r_tx_count  <= '0;
        end else begin
            if (r_state == c_ST_IDLE && ap_start) begin
                r_state <= c_ST_RUN;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_xfer) begin
                r_tx_count <= r_tx_count + 32'd1;
            end
            r_or_full   <= w_or_full_nxt;
            r_or_word   <= w_or_word_nxt;
            r_out_east  <= w_east_nxt;
            r_out_south <= w_south_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {local_in_dest, local_in_data};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_edge_es_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_edge_es_tx
// Description : Bench for pe_edge_es_tx against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_edge_es_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic         ap_start;
    logic [127:0] local_in_data;
    logic         local_in_dest;
    logic         local_in_valid;
    logic         local_in_ready;
    logic [129:0] in_from_east;
    logic [129:0] in_from_south;
    logic [129:0] out_to_east;
    logic [129:0] out_to_south;
    logic [31:0]  tx_count;
    logic         idle;

    int checks = 0;
    int errors = 0;

    bit           m_run;
    logic [128:0] m_q[$];
    bit           m_or_full;
    logic [128:0] m_or;
    logic [31:0]  m_tx;

    logic [127:0] w_words[5];
    logic [127:0] wa, wb, wc;
    logic [31:0]  tx_before;

    pe_edge_es_tx dut (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .local_in_data(local_in_data), .local_in_dest(local_in_dest),
        .local_in_valid(local_in_valid), .local_in_ready(local_in_ready),
        .in_from_east(in_from_east), .in_from_south(in_from_south),
        .out_to_east(out_to_east), .out_to_south(out_to_south),
        .tx_count(tx_count), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Return buses carry random junk everywhere except the ready bit.
    task automatic set_rdy(input bit e, input bit s);
        in_from_east  = {1'($urandom), e, rnd128()};
        in_from_south = {1'($urandom), s, rnd128()};
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [129:0] exp_bus(input bit dest_sel);
        logic [129:0] e = '0;
        if (m_or_full && (m_or[128] == dest_sel)) e = {2'b10, m_or[127:0]};
        return e;
    endfunction

    task automatic model_clear();
        m_run = 0; m_q.delete(); m_or_full = 0; m_or = '0; m_tx = '0;
    endtask

    // One clock edge of the intended behaviour, using the inputs as currently driven.
    task automatic model_step();
        bit rdy, xfer;
        if (!reset) begin
            model_clear();
            return;
        end
        rdy  = m_run && (m_q.size() < 4);
        xfer = m_or_full && (m_or[128] ? in_from_south[128] : in_from_east[128]);
        if (xfer) m_tx++;
        if (m_q.size() > 0 && (!m_or_full || xfer)) begin
            m_or = m_q.pop_front();
            m_or_full = 1;
        end else if (xfer) begin
            m_or_full = 0;
        end
        if (local_in_valid && rdy) m_q.push_back({local_in_dest, local_in_data});
        if (!m_run && ap_start) m_run = 1;
    endtask

    task automatic check_all();
        chk("out_to_east", out_to_east, exp_bus(1'b0));
        chk("out_to_south", out_to_south, exp_bus(1'b1));
        chk("local_in_ready", local_in_ready, m_run && (m_q.size() < 4));
        chk("idle", idle, m_run && m_q.size() == 0 && !m_or_full);
        chk("tx_count", tx_count, m_tx);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push_word(input bit d, input logic [127:0] data);
        bit r;
        bit accepted = 0;
        local_in_valid = 1; local_in_dest = d; local_in_data = data;
        for (int i = 0; i < 20; i++) begin
            r = m_run && (m_q.size() < 4);
            tick();
            if (r) begin
                accepted = 1;
                break;
            end
        end
        chk("push_accept", accepted, 1);
        local_in_valid = 0;
    endtask

    initial begin
        reset = 0; ap_start = 0; local_in_valid = 0; local_in_dest = 0;
        local_in_data = '0;
        set_rdy(0, 0);
        model_clear();
        #12;
        check_all();
        tick();
        reset = 1;

        // Valid without start: nothing accepted, buses stay quiet.
        local_in_valid = 1; local_in_data = rnd128();
        for (int i = 0; i < 10; i++) tick();
        chk("prestart_ready", local_in_ready, 0);
        local_in_valid = 0;

        ap_start = 1; tick(); ap_start = 0;

        // Single east word: visible one edge after acceptance.
        set_rdy(1, 0);
        push_word(0, {32{4'hA, 4'h5}});
        chk("lat_pre", out_to_east[129], 0);
        tick();
        chk("lat_east_valid", out_to_east[129], 1);
        tick();
        chk("single_tx", tx_count, 1);
        chk("single_idle", idle, 1);

        // Backpressure on south: 4 queued plus 1 held in the output register.
        set_rdy(1, 0);
        for (int i = 0; i < 5; i++) begin
            w_words[i] = rnd128();
            push_word(1, w_words[i]);
        end
        chk("bp_ready_low", local_in_ready, 0);
        set_rdy(0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_order", out_to_south, {2'b10, w_words[i]});
            tick();
        end
        chk("bp_tx", tx_count, 6);
        chk("bp_idle", idle, 1);

        // Mixed routing with a stalled south head blocking the east tail.
        set_rdy(1, 0);
        wa = rnd128(); wb = rnd128(); wc = rnd128();
        tx_before = m_tx;
        push_word(0, wa); push_word(1, wb); push_word(0, wc);
        for (int i = 0; i < 5; i++) tick();
        chk("mixed_tx", tx_count, tx_before + 1);
        chk("mixed_south_head", out_to_south, {2'b10, wb});
        chk("mixed_east_quiet", out_to_east, 0);
        set_rdy(1, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("mixed_drain_tx", tx_count, tx_before + 3);

        // Reset mid-burst discards everything immediately.
        set_rdy(0, 0);
        push_word(0, rnd128()); push_word(1, rnd128()); push_word(0, rnd128());
        #2 reset = 0;
        #1;
        model_clear();
        check_all();
        chk("rst_east", out_to_east, 0);
        chk("rst_tx", tx_count, 0);
        tick();
        reset = 1;
        set_rdy(1, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_hold_idle_state", local_in_ready, 0);
        ap_start = 1; tick(); ap_start = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("rst_no_words", tx_count, 0);

        // Counter wrap.
        set_rdy(0, 0);
        push_word(0, rnd128());
        tick();
        @(negedge clk);
        force dut.r_tx_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_tx_count;
        m_tx = 32'hFFFF_FFFF;
        set_rdy(1, 0);
        tick();
        chk("wrap_tx", tx_count, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            local_in_valid = 1'($urandom);
            local_in_dest  = 1'($urandom);
            local_in_data  = rnd128();
            ap_start       = 1'($urandom);
            set_rdy($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
